// File: rtl/writeback_arbiter_if.sv
// Writeback bus between the load/ALU producers, the arbiter and the register file write port.
// The arbiter attaches through the slave modport; producers and consumers use the master modport.
interface writeback_arbiter_if;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        WE3;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic [4:0]  q_rd;
  logic        q_hit;
  logic [31:0] q_data;
  logic [2:0]  occ;

  modport slave (
    input  ld_valid, ld_rd, ld_data, alu_valid, alu_rd, alu_data, q_rd,
    output ld_ready, alu_ready, WE3, A3, WD3, q_hit, q_data, occ
  );

  modport master (
    output ld_valid, ld_rd, ld_data, alu_valid, alu_rd, alu_data, q_rd,
    input  ld_ready, alu_ready, WE3, A3, WD3, q_hit, q_data, occ
  );
endinterface

// File: rtl/writeback_arbiter.sv
// Merges load and ALU results into a 4-entry FIFO that drains one register-file write per cycle.
// Define WB_FORWARD_EN to build the pending-write forwarding query (q_hit/q_data).
module writeback_arbiter (
  input  logic              clk,
  input  logic              rst,
  writeback_arbiter_if.slave wb
);
  localparam int DEPTH = 4;

  logic [4:0]  rd_q   [DEPTH];
  logic [31:0] data_q [DEPTH];
  logic [1:0]  head_q, head_d;
  logic [1:0]  tail_q, tail_d;
  logic [2:0]  occ_q, occ_d;

  logic        ld_ready_s, alu_ready_s;
  logic        ld_push_s, alu_push_s, pop_s;
  logic [1:0]  push_cnt_s;
  logic [1:0]  alu_slot_s;

  // Readiness looks only at registered occupancy; a pop this cycle does not free a slot early.
  always_comb begin
    ld_ready_s  = rst & (occ_q != 3'd4);
    alu_ready_s = rst & ((occ_q <= 3'd2) | ((occ_q == 3'd3) & ~wb.ld_valid));
  end

  assign wb.ld_ready  = ld_ready_s;
  assign wb.alu_ready = alu_ready_s;

  // Handshakes to x0 complete but never occupy a slot.
  assign ld_push_s  = wb.ld_valid  & ld_ready_s  & (wb.ld_rd  != 5'd0);
  assign alu_push_s = wb.alu_valid & alu_ready_s & (wb.alu_rd != 5'd0);
  assign pop_s      = (occ_q != 3'd0);

  // Next-state pointers and occupancy; the load takes the tail slot first.
  always_comb begin
    push_cnt_s = {1'b0, ld_push_s} + {1'b0, alu_push_s};
    alu_slot_s = tail_q + {1'b0, ld_push_s};
    tail_d     = tail_q + push_cnt_s;
    head_d     = head_q + {1'b0, pop_s};
    occ_d      = occ_q + {1'b0, push_cnt_s} - {2'b00, pop_s};
  end

  // Queue state update with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q <= 2'd0;
      tail_q <= 2'd0;
      occ_q  <= 3'd0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= 5'd0;
        data_q[i] <= 32'd0;
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
      if (ld_push_s) begin
        rd_q[tail_q]   <= wb.ld_rd;
        data_q[tail_q] <= wb.ld_data;
      end
      if (alu_push_s) begin
        rd_q[alu_slot_s]   <= wb.alu_rd;
        data_q[alu_slot_s] <= wb.alu_data;
      end
    end
  end

  assign wb.occ = occ_q;
  assign wb.WE3 = pop_s;
  assign wb.A3  = pop_s ? rd_q[head_q]   : 5'd0;
  assign wb.WD3 = pop_s ? data_q[head_q] : 32'd0;

`ifdef WB_FORWARD_EN
  logic        q_hit_s;
  logic [31:0] q_data_s;
  logic [1:0]  fwd_idx_s;

  // Walk oldest to youngest so the last match left standing is the youngest pending write.
  always_comb begin
    q_hit_s   = 1'b0;
    q_data_s  = 32'd0;
    fwd_idx_s = 2'd0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx_s = head_q + 2'(i);
      if ((3'(i) < occ_q) && (rd_q[fwd_idx_s] == wb.q_rd) && (wb.q_rd != 5'd0)) begin
        q_hit_s  = 1'b1;
        q_data_s = data_q[fwd_idx_s];
      end else begin
        q_hit_s  = q_hit_s;
        q_data_s = q_data_s;
      end
    end
  end

  assign wb.q_hit  = q_hit_s;
  assign wb.q_data = q_data_s;
`else
  assign wb.q_hit  = 1'b0;
  assign wb.q_data = 32'd0;
`endif

endmodule
